// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, the NOP reset instruction and the address helpers.
package pkg_instr_fetch;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // RV32I "addi x0, x0, 0"
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port shared between the fetch unit and the memory.
// The fetch unit is the master; the memory or a bench model takes the slave side.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_timeout.sv
// Watchdog for the fetch WAIT state: counts enabled cycles and flags the last allowed one.
// expired is combinational so the FSM can abort on the very edge the budget runs out.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a stuck enable can never wrap back to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/WAIT handshake with instruction memory,
// owning the PC, the instruction register and single-cycle status pulses.
module instr_fetch_unit
  import pkg_instr_fetch::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_start,
  input  logic                      pc_we,
  input  logic [31:0]               pc_next,
  instr_fetch_unit_if.master        bus,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic [31:0]               pc_cur,
  output logic [31:0]               pc_old,
  output logic                      busy,
  output logic                      misaligned,
  output logic                      fetch_fault
);

  fetch_state_t state;
  logic [31:0]  target;
  logic         in_wait;
  logic         wd_expired;

  // A same-cycle pc_we redirects the fetch that fetch_start launches
  assign target  = pc_we ? pc_next : pc_cur;
  assign in_wait = (state == WAIT);

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wd_expired)
  );

  // Status pulses default low every cycle; only the transition that earns them raises them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc_cur        <= RESET_PC;
      pc_old        <= RESET_PC;
      instr         <= NOP_INSTR;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
      instr_valid   <= 1'b0;
      misaligned    <= 1'b0;
      fetch_fault   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      fetch_fault <= 1'b0;

      case (state)
        IDLE: begin
          if (pc_we) begin
            pc_cur <= pc_next;
          end
          if (fetch_start) begin
            if (!is_word_aligned(target)) begin
              misaligned <= 1'b1;
            end else begin
              state         <= REQ;
              bus.imem_req  <= 1'b1;
              bus.imem_addr <= target;
              busy          <= 1'b1;
            end
          end
        end

        REQ: begin
          if (bus.imem_ready) begin
            state        <= WAIT;
            bus.imem_req <= 1'b0;
          end
        end

        WAIT: begin
          // Data wins over the watchdog if both land on the same edge
          if (bus.imem_rvalid) begin
            instr       <= bus.imem_rdata;
            pc_old      <= bus.imem_addr;
            pc_cur      <= bus.imem_addr + INSTR_BYTES;
            instr_valid <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else if (wd_expired) begin
            fetch_fault <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          bus.imem_req <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  status_pulses_exclusive: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0({instr_valid, misaligned, fetch_fault})
  );

  req_only_in_req_state: assert property (
    @(posedge clk) disable iff (reset)
    bus.imem_req |-> (state == REQ)
  );

  busy_tracks_state: assert property (
    @(posedge clk) disable iff (reset)
    busy == (state != IDLE)
  );

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, max cycles spent in WAIT before abort.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-high reset.
REQ-006 fetch_start  in  1  control FSM pulse, request the next instruction.
REQ-007 pc_we  in  1  load pc_next into PC (branch/jump/ALU writeback).
REQ-008 pc_next  in  32  new PC value.
REQ-009 imem_req  out  1  memory read request.
REQ-010 imem_addr  out  32  word-aligned read address.
REQ-011 imem_ready  in  1  memory accepts request this cycle.
REQ-012 imem_rvalid  in  1  read data valid.
REQ-013 imem_rdata  in  32  read data.
REQ-014 instr  out  32  latched instruction (instruction register).
REQ-015 instr_valid  out  1  one-cycle pulse, instr updated.
REQ-016 pc_cur  out  32  address of next fetch.
REQ-017 pc_old  out  32  address of the instruction held in instr.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 misaligned  out  1  one-cycle pulse, fetch target not word-aligned.
REQ-020 fetch_fault  out  1  one-cycle pulse, WAIT timed out.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT; all transitions registered on the rising edge of clk.
REQ-022 IDLE and fetch_start: target = pc_we ? pc_next : pc_cur; target[1:0]!=0 -> misaligned pulse next cycle, stay IDLE; else -> REQ with imem_addr = target.
REQ-023 IDLE and pc_we: pc_cur <= pc_next on that edge, whether or not fetch_start is high.
REQ-024 REQ: imem_req=1, imem_addr held stable; imem_ready=1 -> WAIT, else stay REQ.
REQ-025 WAIT and imem_rvalid: instr <= imem_rdata, pc_old <= imem_addr, pc_cur <= imem_addr+4 (modulo 2^32), instr_valid=1 the following cycle, -> IDLE.
REQ-026 Minimum latency: fetch_start sampled at edge N -> imem_req high cycle N+1 -> WAIT at N+2 with ready -> rvalid sampled at N+2 -> instr_valid high during cycle N+3.
REQ-027 WAIT counter SHALL count cycles in WAIT; reaching TIMEOUT without rvalid -> fetch_fault pulse, -> IDLE, pc_cur/pc_old/instr unchanged.
REQ-028 imem_rvalid in IDLE or REQ SHALL be ignored.
REQ-029 pc_we or fetch_start outside IDLE SHALL be ignored, no state change.
REQ-030 imem_req SHALL be 0 in IDLE and WAIT.
REQ-031 instr_valid, misaligned and fetch_fault SHALL never be high in the same cycle.

Reset
REQ-032 Reset SHALL force: state IDLE, pc_cur=RESET_PC, pc_old=RESET_PC, instr=32'h0000_0013 (NOP), imem_req=0, instr_valid=0, misaligned=0, fetch_fault=0, busy=0, WAIT counter=0.
REQ-033 Reset asserted in REQ or WAIT SHALL abort the transaction; rvalid arriving after reset deassertion SHALL be ignored.

Structure
REQ-034 Typedef fetch_state_t (IDLE/REQ/WAIT) and constant NOP_INSTR SHALL live in shared package pkg_instr_fetch.
REQ-035 The WAIT watchdog SHALL be a sub-module fetch_timeout_counter (clear, enable, expired).

Verification
REQ-036 Reset, NOP at M[0], fetch_start, ready/rvalid immediate -> instr=32'h00000013, pc_old=0, pc_cur=4, instr_valid at N+3.
REQ-037 imem_ready delayed 3 cycles -> imem_req held high 4 cycles, imem_addr stable, single instr_valid pulse.
REQ-038 pc_we with pc_next=32'h40 plus fetch_start in IDLE -> imem_addr=32'h40, after rvalid pc_cur=32'h44.
REQ-039 pc_we with pc_next=32'h42 plus fetch_start -> misaligned pulse, no imem_req, state IDLE.
REQ-040 rvalid withheld for TIMEOUT cycles -> fetch_fault pulse, pc_cur unchanged; pc_cur=32'hFFFFFFFC fetch -> pc_cur wraps to 0.
REQ-041 Reset asserted mid-WAIT, late rvalid -> all outputs at reset values, no instr_valid.
